rect_draw_scanner: RTL and testbench

//  Parametrised successor to the fixed-size square pixel counters. Walks a runtime-sized

---
 rtl/draw_pkg.sv | 12 +
 rtl/rect_draw_scanner_if.sv | 33 +++
 rtl/rect_draw_scanner_counter.sv | 38 +++
 rtl/rect_draw_scanner.sv | 88 ++++++++
 tb/tb_rect_draw_scanner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the rectangle draw scanner: mode codes and FSM states.
package draw_pkg;

  localparam logic [1:0] MODE_FILL    = 2'd0;
  localparam logic [1:0] MODE_OUTLINE = 2'd1;
  localparam logic [1:0] MODE_ERASE   = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/rect_draw_scanner_if.sv
// Request/pixel bus between the board FSM, the scanner and the VGA adapter.
// master = requester side (also supplies the adapter's ready), slave = scanner.
interface rect_draw_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int DW = 5,
  parameter int CW = 3
);
  logic          start;
  logic [1:0]    mode;
  logic [XW-1:0] x_origin;
  logic [YW-1:0] y_origin;
  logic [DW-1:0] rect_w;
  logic [DW-1:0] rect_h;
  logic [CW-1:0] colour_in;
  logic          ready;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] colour_out;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, x_origin, y_origin, rect_w, rect_h, colour_in, ready,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, mode, x_origin, y_origin, rect_w, rect_h, colour_in, ready,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/rect_draw_scanner_counter.sv
// Raster col/row counter with runtime limits. load clears to (0,0);
// last flags the final pixel (col_max,row_max).
module rect_scan_counter #(
  parameter int DW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] col_max,
  input  logic [DW-1:0] row_max,
  output logic [DW-1:0] col,
  output logic [DW-1:0] row,
  output logic          last
);
  logic col_end;

  assign col_end = (col == col_max);
  assign last    = col_end && (row == row_max);

  // Step one pixel in raster order; wrap to (0,0) after the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rect_draw_scanner.sv
// Walks a runtime-sized rectangle and emits one pixel per accepted cycle.
// Fill, outline and erase modes; start/busy/done handshake; ready backpressure.
module rect_draw_scanner
  import draw_pkg::*;
#(
  parameter int             XW        = 9,
  parameter int             YW        = 8,
  parameter int             DW        = 5,
  parameter int             CW        = 3,
  parameter logic [CW-1:0]  BG_COLOUR = '0
) (
  input  logic  clock,
  input  logic  reset,
  rect_draw_if.slave bus
);
  logic [1:0]    state;
  logic [1:0]    mode_r;
  logic [XW-1:0] x_org;
  logic [YW-1:0] y_org;
  logic [DW-1:0] w_r, h_r;
  logic [CW-1:0] colour_r;
  logic [DW-1:0] col, row, col_max, row_max;
  logic          last, accept, drawable, advance, empty_req;

  assign col_max   = w_r - 1'b1;
  assign row_max   = h_r - 1'b1;
  assign accept    = (state == S_IDLE) && bus.start;
  assign empty_req = (bus.rect_w == '0) || (bus.rect_h == '0);

  // Outline mode only plots the border ring; interior pixels are skipped
  // in one cycle each without waiting on the adapter.
  assign drawable = (mode_r != MODE_OUTLINE) || (col == '0) || (col == col_max) ||
                    (row == '0) || (row == row_max);
  assign advance  = (state == S_DRAW) && (!drawable || bus.ready);

  rect_scan_counter #(.DW(DW)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .en      (advance),
    .col_max (col_max),
    .row_max (row_max),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  // Control FSM: IDLE -> DRAW -> DONE -> IDLE; zero-sized requests skip DRAW.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state <= empty_req ? S_DONE : S_DRAW;
        S_DRAW:  if (advance && last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request latches, captured only when a start is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_r   <= MODE_FILL;
      x_org    <= '0;
      y_org    <= '0;
      w_r      <= '0;
      h_r      <= '0;
      colour_r <= '0;
    end else if (accept) begin
      mode_r   <= bus.mode;
      x_org    <= bus.x_origin;
      y_org    <= bus.y_origin;
      w_r      <= bus.rect_w;
      h_r      <= bus.rect_h;
      colour_r <= bus.colour_in;
    end
  end

  // Coordinates wrap at the screen-register width; no clipping.
  assign bus.x_out      = x_org + XW'(col);
  assign bus.y_out      = y_org + YW'(row);
  assign bus.colour_out = (mode_r == MODE_ERASE) ? BG_COLOUR : colour_r;
  assign bus.plot       = (state == S_DRAW) && drawable;
  assign bus.busy       = (state == S_DRAW) || (state == S_DONE);
  assign bus.done       = (state == S_DONE);
endmodule

// File: tb/tb_rect_draw_scanner.sv
// Randomized bench for rect_draw_scanner against a raster-list reference model.
module tb_rect_draw_scanner;
  localparam int XW = 9, YW = 8, DW = 5, CW = 3;
  localparam int BG = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rect_draw_if #(.XW(XW), .YW(YW), .DW(DW), .CW(CW)) bus ();

  rect_draw_scanner #(.XW(XW), .YW(YW), .DW(DW), .CW(CW), .BG_COLOUR(CW'(BG))) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  // Expected pixel list: raster order, border only for outline, wrap mod screen regs.
  task automatic build(input int mode, input int xo, input int yo,
                       input int w, input int h, input int colour);
    pix_t p;
    exp_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (mode != 1 || c == 0 || c == w - 1 || r == 0 || r == h - 1) begin
          p.x = (xo + c) % (1 << XW);
          p.y = (yo + r) % (1 << YW);
          p.c = (mode == 2) ? BG : colour;
          exp_q.push_back(p);
        end
  endtask

  task automatic drive_req(input int mode, input int xo, input int yo,
                           input int w, input int h, input int colour);
    bus.mode      = 2'(mode);
    bus.x_origin  = XW'(xo);
    bus.y_origin  = YW'(yo);
    bus.rect_w    = DW'(w);
    bus.rect_h    = DW'(h);
    bus.colour_in = CW'(colour);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  // rdy_ctl: 0 always ready, 1 random ready, 2 three-cycle stall at third column of row 0.
  task automatic run(input int mode, input int xo, input int yo, input int w,
                     input int h, input int colour, input int rdy_ctl, input string tag);
    int   cyc = 0, stalls = 0, stall_left = 0;
    bit   held = 0, stalled_once = 0;
    int   hx = 0, hy = 0, hc = 0;
    pix_t p;
    build(mode, xo, yo, w, h, colour);
    drive_req(mode, xo, yo, w, h, colour);
    bus.ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (held)
        chk({tag, " hold"}, int'(bus.plot && bus.x_out == XW'(hx) && bus.y_out == YW'(hy)
                                && bus.colour_out == CW'(hc)), 1);
      if (bus.done) break;
      if (cyc > 2000) begin
        chk({tag, " done timeout"}, cyc, 1 + w * h + stalls);
        break;
      end
      chk({tag, " busy"}, int'(bus.busy), 1);
      case (rdy_ctl)
        0: bus.ready = 1'b1;
        1: bus.ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stalled_once && bus.plot && int'(bus.x_out) == (xo + 2) % (1 << XW)
              && int'(bus.y_out) == yo) begin
            stall_left   = 3;
            stalled_once = 1;
          end
          bus.ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      held = 0;
      if (bus.plot) begin
        if (bus.ready) begin
          if (exp_q.size() == 0) chk({tag, " unexpected plot"}, int'(bus.plot), 0);
          else begin
            p = exp_q.pop_front();
            chk({tag, " x"}, int'(bus.x_out), p.x);
            chk({tag, " y"}, int'(bus.y_out), p.y);
            chk({tag, " colour"}, int'(bus.colour_out), p.c);
          end
        end else begin
          stalls++;
          held = 1;
          hx = int'(bus.x_out); hy = int'(bus.y_out); hc = int'(bus.colour_out);
        end
      end
      // A start while busy must not disturb the draw in flight.
      if (cyc == 2) begin
        bus.start = 1'b1;
        drive_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 255)), 3, 3, int'($urandom_range(0, 7)));
      end else bus.start = 1'b0;
    end
    chk({tag, " done cycle"}, cyc, 1 + w * h + stalls);
    chk({tag, " pixels left"}, exp_q.size(), 0);
    chk({tag, " plot in done"}, int'(bus.plot), 0);
    // Start during the done cycle is ignored.
    drive_req(0, 1, 1, 3, 3, 7);
    bus.start = 1'b1;
    bus.ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk({tag, " idle busy"}, int'(bus.busy), 0);
    chk({tag, " idle plot"}, int'(bus.plot), 0);
    chk({tag, " idle done"}, int'(bus.done), 0);
  endtask

  initial begin
    int plots, w, h;
    bus.start = 1'b0;
    bus.ready = 1'b1;
    drive_req(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset x_out", int'(bus.x_out), 0);
    chk("reset y_out", int'(bus.y_out), 0);
    chk("reset colour", int'(bus.colour_out), 0);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    run(0, 10, 20, 4, 3, 2, 0, "fill");
    run(1, 10, 20, 4, 3, 2, 0, "outline");
    run(0, 10, 20, 4, 3, 2, 2, "stall");
    run(0, 10, 20, 0, 3, 2, 0, "w0");
    run(0, 10, 20, 4, 0, 2, 0, "h0");
    run(2, 510, 7, 4, 1, 5, 0, "erase");
    run(3, 100, 250, 3, 9, 6, 1, "mode3 wrap");

    // Reset during the 5th pixel of a 4x3 fill aborts without done.
    drive_req(0, 30, 40, 4, 3, 4);
    bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    plots = 0;
    for (int i = 0; i < 50 && plots < 5; i++) begin
      @(negedge clock);
      if (bus.plot) plots++;
    end
    chk("abort reached pixel 5", plots, 5);
    #1 reset = 1'b1;
    #1;
    chk("abort plot", int'(bus.plot), 0);
    chk("abort busy", int'(bus.busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort no done", int'(bus.done), 0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("abort idle busy", int'(bus.busy), 0);
    run(0, 30, 40, 4, 3, 4, 0, "after reset");

    for (int k = 0; k < 20; k++) begin
      w = (k % 7 == 0) ? 31 : int'($urandom_range(0, 7));
      h = int'($urandom_range(0, 7));
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)),
          int'($urandom_range(0, 255)), w, h, int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
